// File: rtl/fetch_redirect_if.sv
// Fetch redirect controller bus: redirect/stall inputs and icache/IF outputs.
// master = fetch controller, slave = pipeline/icache side.
interface fetch_redirect_if #(
  parameter int PC_W = 32
);
  logic            pipe_stall;
  logic            id_redir_valid;
  logic [PC_W-1:0] id_redir_target;
  logic            ex_redir_valid;
  logic [PC_W-1:0] ex_redir_target;
  logic            icache_stall;
  logic            icache_re;
  logic [PC_W-1:0] icache_addr;
  logic [PC_W-1:0] fetch_pc;
  logic            inst_valid;
  logic            squash_id;
  logic            misalign_pulse;

  modport master (
    input  pipe_stall, id_redir_valid, id_redir_target,
    input  ex_redir_valid, ex_redir_target, icache_stall,
    output icache_re, icache_addr, fetch_pc,
    output inst_valid, squash_id, misalign_pulse
  );

  modport slave (
    output pipe_stall, id_redir_valid, id_redir_target,
    output ex_redir_valid, ex_redir_target, icache_stall,
    input  icache_re, icache_addr, fetch_pc,
    input  inst_valid, squash_id, misalign_pulse
  );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC owner: sequences icache reads, resolves ID/EX redirects,
// rides out icache misses and redirects that land mid-miss.
module fetch_redirect_ctrl #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_2000
) (
  input  logic             clk,
  input  logic             rst,
  fetch_redirect_if.master fr
);

  typedef enum logic [1:0] {
    BOOT, RUN, MISS, MISS_REDIR
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_q, pend_d;
  logic            pend_id_q, pend_id_d;

  logic            ex, id, redir, take;
  logic            win_mis;
  logic [PC_W-1:0] ex_tgt, id_tgt, win_tgt;
  logic [PC_W-1:0] seq_pc, mr_tgt;
  logic [PC_W-1:0] addr;
  logic            vld, sq, mis;

  assign ex      = fr.ex_redir_valid;
  assign id      = fr.id_redir_valid;
  assign redir   = ex | id;
  assign ex_tgt  = {fr.ex_redir_target[PC_W-1:2], 2'b00};
  assign id_tgt  = {fr.id_redir_target[PC_W-1:2], 2'b00};
  assign win_tgt = ex ? ex_tgt : id_tgt;
  assign win_mis = ex ? |fr.ex_redir_target[1:0]
                      : |fr.id_redir_target[1:0];
  assign seq_pc  = fr.pipe_stall ? pc_q : pc_q + PC_W'(4);
  // an id redirect may only replace a pending target that came from id
  assign take    = ex | (id & pend_id_q);
  assign mr_tgt  = take ? win_tgt : pend_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_d    = pend_q;
    pend_id_d = pend_id_q;
    addr      = pc_q;
    vld       = 1'b0;
    sq        = 1'b0;
    mis       = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN, MISS: begin
        sq  = ex;
        mis = redir & win_mis;
        if (redir && (fr.icache_stall || state_q == MISS)) begin
          pend_d    = win_tgt;
          pend_id_d = ~ex;
          state_d   = MISS_REDIR;
        end else if (fr.icache_stall) begin
          state_d = MISS;
        end else begin
          addr    = redir ? win_tgt : seq_pc;
          pc_d    = addr;
          vld     = ~redir;
          state_d = RUN;
        end
      end
      MISS_REDIR: begin
        sq        = ex;
        mis       = take & win_mis;
        pend_d    = mr_tgt;
        pend_id_d = take ? ~ex : pend_id_q;
        if (!fr.icache_stall) begin
          addr    = mr_tgt;
          pc_d    = mr_tgt;
          state_d = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      pend_q    <= '0;
      pend_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_id_q <= pend_id_d;
    end
  end

  assign fr.icache_re      = ~rst;
  assign fr.icache_addr    = addr;
  assign fr.fetch_pc       = pc_q;
  assign fr.inst_valid     = vld;
  assign fr.squash_id      = sq;
  assign fr.misalign_pulse = mis;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed-vector bench for fetch_redirect_ctrl.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_fetch_redirect_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fetch_redirect_if #(.PC_W(32)) bus ();

  fetch_redirect_ctrl #(
    .PC_W    (32),
    .RESET_PC(32'h0000_2000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fr (bus)
  );

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic ps, input logic idv,
                       input logic [31:0] idt, input logic exv,
                       input logic [31:0] ext, input logic ics);
    bus.pipe_stall      = ps;
    bus.id_redir_valid  = idv;
    bus.id_redir_target = idt;
    bus.ex_redir_valid  = exv;
    bus.ex_redir_target = ext;
    bus.icache_stall    = ics;
  endtask

  task automatic step(input string tag,
                      input logic ps, input logic idv,
                      input logic [31:0] idt, input logic exv,
                      input logic [31:0] ext, input logic ics,
                      input logic [31:0] e_addr,
                      input logic [31:0] e_fpc,
                      input logic e_v, input logic e_s,
                      input logic e_m);
    drive(ps, idv, idt, exv, ext, ics);
    #1;
    chk({tag, ".re"}, 32'(bus.icache_re), 32'd1);
    chk({tag, ".addr"}, bus.icache_addr, e_addr);
    chk({tag, ".fpc"}, bus.fetch_pc, e_fpc);
    chk({tag, ".vld"}, 32'(bus.inst_valid), 32'(e_v));
    chk({tag, ".sq"}, 32'(bus.squash_id), 32'(e_s));
    chk({tag, ".mis"}, 32'(bus.misalign_pulse), 32'(e_m));
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".re"}, 32'(bus.icache_re), 32'd0);
    chk({tag, ".addr"}, bus.icache_addr, 32'h0000_2000);
    chk({tag, ".fpc"}, bus.fetch_pc, 32'h0000_2000);
    chk({tag, ".vld"}, 32'(bus.inst_valid), 32'd0);
    chk({tag, ".sq"}, 32'(bus.squash_id), 32'd0);
    chk({tag, ".mis"}, 32'(bus.misalign_pulse), 32'd0);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    chk_reset("rst");
    rst = 1'b0;
    //    tag    ps id idt           ex ext           ics addr          fpc           v s m
    step("boot", 0, 0, 0,            0, 0,            0, 32'h2000,     32'h2000,     0,0,0);
    step("seq1", 0, 0, 0,            0, 0,            0, 32'h2004,     32'h2000,     1,0,0);
    step("seq2", 0, 0, 0,            0, 0,            0, 32'h2008,     32'h2004,     1,0,0);
    step("idj",  0, 1, 32'h2100,     0, 0,            0, 32'h2100,     32'h2008,     0,0,0);
    step("idj1", 0, 0, 0,            0, 0,            0, 32'h2104,     32'h2100,     1,0,0);
    step("exid", 0, 1, 32'h2100,     1, 32'h3000,     0, 32'h3000,     32'h2104,     0,1,0);
    step("exid1",0, 0, 0,            0, 0,            0, 32'h3004,     32'h3000,     1,0,0);
    step("to10", 0, 1, 32'h2010,     0, 0,            0, 32'h2010,     32'h3004,     0,0,0);
    step("mis1", 0, 0, 0,            0, 0,            1, 32'h2010,     32'h2010,     0,0,0);
    step("mis2", 0, 0, 0,            1, 32'h4000,     1, 32'h2010,     32'h2010,     0,1,0);
    step("mis3", 0, 0, 0,            0, 0,            1, 32'h2010,     32'h2010,     0,0,0);
    step("mrel", 0, 0, 0,            0, 0,            0, 32'h4000,     32'h2010,     0,0,0);
    step("mrel1",0, 0, 0,            0, 0,            0, 32'h4004,     32'h4000,     1,0,0);
    step("to20", 0, 1, 32'h2020,     0, 0,            0, 32'h2020,     32'h4004,     0,0,0);
    step("ps1",  1, 0, 0,            0, 0,            0, 32'h2020,     32'h2020,     1,0,0);
    step("ps2",  1, 0, 0,            0, 0,            0, 32'h2020,     32'h2020,     1,0,0);
    step("psrel",0, 0, 0,            0, 0,            0, 32'h2024,     32'h2020,     1,0,0);
    step("mal",  0, 0, 0,            1, 32'h2102,     0, 32'h2100,     32'h2024,     0,1,1);
    step("mal1", 0, 0, 0,            0, 0,            0, 32'h2104,     32'h2100,     1,0,0);
    step("tofc", 0, 1, 32'hFFFFFFFC, 0, 0,            0, 32'hFFFFFFFC, 32'h2104,     0,0,0);
    step("wrap", 0, 0, 0,            0, 0,            0, 32'h0,        32'hFFFFFFFC, 1,0,0);
    step("pm1",  0, 0, 0,            0, 0,            1, 32'h0,        32'h0,        0,0,0);
    step("pmrel",0, 0, 0,            0, 0,            0, 32'h4,        32'h0,        1,0,0);
    step("mr1",  0, 1, 32'h5000,     0, 0,            1, 32'h4,        32'h4,        0,0,0);
    step("mr2",  0, 1, 32'h6000,     0, 0,            1, 32'h4,        32'h4,        0,0,0);
    step("mr3",  0, 0, 0,            1, 32'h7000,     1, 32'h4,        32'h4,        0,1,0);
    step("mr4",  0, 1, 32'h8000,     0, 0,            1, 32'h4,        32'h4,        0,0,0);
    step("mrrel",0, 0, 0,            0, 0,            0, 32'h7000,     32'h4,        0,0,0);
    step("mrrel1",0,0, 0,            0, 0,            0, 32'h7004,     32'h7000,     1,0,0);
    step("rm0",  0, 0, 0,            0, 0,            1, 32'h7004,     32'h7004,     0,0,0);
    drive(0, 0, 0, 0, 0, 1);
    #1;
    chk("rm.addr", bus.icache_addr, 32'h7004);
    chk("rm.vld", 32'(bus.inst_valid), 32'd0);
    rst = 1'b1;
    #1;
    chk_reset("rmid");
    @(negedge clk);
    rst = 1'b0;
    step("boot2",0, 0, 0,            0, 0,            0, 32'h2000,     32'h2000,     0,0,0);
    step("seq3", 0, 0, 0,            0, 0,            0, 32'h2004,     32'h2000,     1,0,0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
